// File: rtl/uc_processador.sv
// Multicycle LEGv8-subset control unit: fetch/decode/exec(/wb), drives datapath controls, owns PC and IR.
// Latency: 3 cycles per instruction, 4 for LDUR; first FETCH the cycle after start.
// Backpressure: none, runs freely once started. Optional CBNZ decode via `UC_CBNZ_EN.
module uc_processador #(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [4:0]  Ra,
  output logic [4:0]  Rb,
  output logic [4:0]  Rw,
  output logic        WE_reg,
  output logic        WE_mem,
  output logic [63:0] OFFSET,
  output logic [1:0]  OP_MEM_I,
  output logic        ADD_SUB,
  input  logic [5:0]  flags,
  output logic [63:0] pc,
  output logic        halted,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_ADD,
    C_SUB,
    C_ADDI,
    C_SUBI,
    C_LDUR,
    C_STUR,
    C_B,
    C_CBZ,
    C_CBNZ,
    C_BAD
  } iclass_t;

  function automatic iclass_t classify(input logic [31:0] w);
    iclass_t c;
    c = C_BAD;
    if      (w[31:21] == 11'b10001011000) c = C_ADD;
    else if (w[31:21] == 11'b11001011000) c = C_SUB;
    else if (w[31:22] == 10'b1001000100)  c = C_ADDI;
    else if (w[31:22] == 10'b1101000100)  c = C_SUBI;
    else if (w[31:21] == 11'b11111000010) c = C_LDUR;
    else if (w[31:21] == 11'b11111000000) c = C_STUR;
    else if (w[31:26] == 6'b000101)       c = C_B;
    else if (w[31:24] == 8'b10110100)     c = C_CBZ;
`ifdef UC_CBNZ_EN
    else if (w[31:24] == 8'b10110101)     c = C_CBNZ;
`endif
    return c;
  endfunction

  state_t      state, state_nxt;
  logic [31:0] ir;
  iclass_t     dec_cls, ir_cls;
  logic        pc_step;
  logic        cb_taken;
  logic [63:0] b_disp, cb_disp, pc_nxt;
  logic [4:0]  f_rd, f_rn, f_rm;

  // Only the zero flag and IR's opcode/offset bits are consumed after DECODE.
  logic unused_bits;
  assign unused_bits = ^{flags[5:1], ir[4:0]};

  assign dec_cls   = classify(imem_data);
  assign ir_cls    = classify(ir);
  assign imem_addr = pc;

  assign f_rd = imem_data[4:0];
  assign f_rn = imem_data[9:5];
  assign f_rm = imem_data[20:16];

  assign b_disp   = {{36{ir[25]}}, ir[25:0], 2'b00};
  assign cb_disp  = {{43{ir[23]}}, ir[23:5], 2'b00};
  assign cb_taken = (ir_cls == C_CBZ  &&  flags[0]) ||
                    (ir_cls == C_CBNZ && !flags[0]);

  always_comb begin
    pc_nxt = pc + 64'd4;
    if (ir_cls == C_B)
      pc_nxt = pc + b_disp;
    else if (cb_taken)
      pc_nxt = pc + cb_disp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Write enables decode straight from the state register so reset kills them at once.
  always_comb begin
    state_nxt = state;
    WE_reg    = 1'b0;
    WE_mem    = 1'b0;
    pc_step   = 1'b0;
    case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = (dec_cls == C_BAD) ? S_HALT : S_EXEC;
      S_EXEC: begin
        WE_reg = (ir_cls == C_ADD)  || (ir_cls == C_SUB) ||
                 (ir_cls == C_ADDI) || (ir_cls == C_SUBI);
        WE_mem = (ir_cls == C_STUR);
        if (ir_cls == C_LDUR) begin
          state_nxt = S_WB;
        end else begin
          state_nxt = S_FETCH;
          pc_step   = 1'b1;
        end
      end
      S_WB: begin
        WE_reg    = 1'b1;
        pc_step   = 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      retired <= 32'd0;
    end else if (pc_step) begin
      pc      <= pc_nxt;
      retired <= retired + 32'd1;
    end
  end

  // Field outputs are captured once per instruction and then held until the next DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir       <= 32'd0;
      halted   <= 1'b0;
      Ra       <= 5'd0;
      Rb       <= 5'd0;
      Rw       <= 5'd0;
      OFFSET   <= 64'd0;
      OP_MEM_I <= 2'd0;
      ADD_SUB  <= 1'b0;
    end else if (state == S_DECODE) begin
      ir <= imem_data;
      case (dec_cls)
        C_ADD, C_SUB: begin
          Ra       <= f_rn;
          Rb       <= f_rm;
          Rw       <= f_rd;
          OP_MEM_I <= 2'd0;
          ADD_SUB  <= (dec_cls == C_SUB);
        end
        C_ADDI, C_SUBI: begin
          Ra       <= f_rn;
          Rb       <= f_rn;
          Rw       <= f_rd;
          OFFSET   <= {52'd0, imem_data[21:10]};
          OP_MEM_I <= 2'd2;
          ADD_SUB  <= (dec_cls == C_SUBI);
        end
        C_LDUR, C_STUR: begin
          Ra       <= f_rd;
          Rb       <= f_rn;
          Rw       <= f_rd;
          OFFSET   <= {{55{imem_data[20]}}, imem_data[20:12]};
          OP_MEM_I <= 2'd1;
          ADD_SUB  <= 1'b0;
        end
        C_CBZ, C_CBNZ: begin
          Ra       <= f_rd;
          Rb       <= 5'd31;
          OP_MEM_I <= 2'd0;
          ADD_SUB  <= 1'b0;
        end
        C_BAD:   halted <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uc_processador.sv
// Bench for uc_processador: ROM programs executed by an instruction-level model; retirements scored by a monitor.
module tb_uc_processador;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [63:0] imem_addr;
  logic [31:0] imem_data = 32'd0;
  logic [4:0]  Ra, Rb, Rw;
  logic        WE_reg, WE_mem;
  logic [63:0] OFFSET;
  logic [1:0]  OP_MEM_I;
  logic        ADD_SUB;
  logic [5:0]  flags;
  logic [63:0] pc;
  logic        halted;
  logic [31:0] retired;

  always #5 clk = ~clk;

  uc_processador #(.RESET_PC(64'd0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .Ra(Ra), .Rb(Rb), .Rw(Rw), .WE_reg(WE_reg), .WE_mem(WE_mem),
    .OFFSET(OFFSET), .OP_MEM_I(OP_MEM_I), .ADD_SUB(ADD_SUB),
    .flags(flags), .pc(pc), .halted(halted), .retired(retired)
  );

  typedef enum {K_ADD, K_SUB, K_ADDI, K_SUBI, K_LDUR, K_STUR, K_B, K_CBZ, K_CBNZ, K_BAD} kind_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ret;
    int          lat;
    int          wer;
    int          wem;
    logic [4:0]  ra, rb, rw;
    logic [63:0] off;
    logic [1:0]  op;
    logic        as;
    logic [5:0]  chk;   // ra, rb, rw, off, op, as
  } exp_t;

  kind_t pk [0:63];
  int    prd [0:63], prn [0:63], prm [0:63], pimm [0:63];
  logic [31:0] rom [0:63];

  exp_t        exp_q[$];
  exp_t        me;
  bit          mon_en = 0;
  bit          flag_z = 0;
  bit          exp_halt;
  logic [63:0] exp_pc;
  logic [31:0] exp_ret;
  int          n_checks = 0, n_err = 0;

  always @(posedge clk)
    imem_data <= (imem_addr < 64'd256) ? rom[imem_addr[7:2]] : 32'hFFFF_FFFF;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] enc(kind_t k, int rd, int rn, int rm, int imm);
    logic [4:0]  d, n, m;
    logic [31:0] v;
    d = rd[4:0]; n = rn[4:0]; m = rm[4:0]; v = imm;
    case (k)
      K_ADD:  return {11'b10001011000, m, 6'd0, n, d};
      K_SUB:  return {11'b11001011000, m, 6'd0, n, d};
      K_ADDI: return {10'b1001000100, v[11:0], n, d};
      K_SUBI: return {10'b1101000100, v[11:0], n, d};
      K_LDUR: return {11'b11111000010, v[8:0], 2'b00, n, d};
      K_STUR: return {11'b11111000000, v[8:0], 2'b00, n, d};
      K_B:    return {6'b000101, v[25:0]};
      K_CBZ:  return {8'b10110100, v[18:0], d};
      K_CBNZ: return {8'b10110101, v[18:0], d};
      default: return (imm == 0) ? 32'hFFFF_FFFF : 32'h0000_0000;
    endcase
  endfunction

  // Monitor: accumulates per-instruction observations, scores each retirement.
  int cyc = 0, wer_cnt = 0, wem_cnt = 0;
  bit prev_start = 0, wer_prev = 0;
  logic [31:0] last_ret = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      cyc = 0; wer_cnt = 0; wem_cnt = 0; prev_start = 0; wer_prev = 0; last_ret = 0;
    end else begin
      cyc++;
      wer_cnt += int'(WE_reg);
      wem_cnt += int'(WE_mem);
      if (start && !prev_start) cyc = -1;
      prev_start = start;
      if (retired != last_ret) begin
        if (mon_en) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL unexpected_retire: got retired=%0d, required no retirement", retired);
          end else begin
            me = exp_q.pop_front();
            chk("pc", pc, me.pc);
            chk("imem_addr", imem_addr, me.pc);
            chk("retired", 64'(retired), 64'(me.ret));
            chk("latency", 64'(cyc), 64'(me.lat));
            chk("we_reg_cycles", 64'(wer_cnt), 64'(me.wer));
            chk("we_mem_cycles", 64'(wem_cnt), 64'(me.wem));
            if (me.lat == 4) chk("ldur_we_in_wb", 64'(wer_prev), 64'd1);
            if (me.chk[5]) chk("Ra", 64'(Ra), 64'(me.ra));
            if (me.chk[4]) chk("Rb", 64'(Rb), 64'(me.rb));
            if (me.chk[3]) chk("Rw", 64'(Rw), 64'(me.rw));
            if (me.chk[2]) chk("OFFSET", OFFSET, me.off);
            if (me.chk[1]) chk("OP_MEM_I", 64'(OP_MEM_I), 64'(me.op));
            if (me.chk[0]) chk("ADD_SUB", 64'(ADD_SUB), 64'(me.as));
          end
        end
        last_ret = retired; cyc = 0; wer_cnt = 0; wem_cnt = 0;
      end
      wer_prev = WE_reg;
    end
  end

  // Instruction-level reference: walks the program by kind, not by bit pattern.
  task automatic build_model(input int steps);
    logic [63:0] mpc;
    kind_t       k;
    int          i;
    bit          taken;
    exp_t        e;
    mpc = 64'd0; exp_halt = 0;
    for (int s = 0; s < steps; s++) begin
      i = int'(mpc[7:2]);
      k = (mpc < 64'd256) ? pk[i] : K_BAD;
`ifndef UC_CBNZ_EN
      if (k == K_CBNZ) k = K_BAD;
`endif
      if (k == K_BAD) begin
        exp_halt = 1;
        break;
      end
      e = '{pc: 0, ret: 0, lat: 3, wer: 0, wem: 0, ra: 0, rb: 0, rw: 0,
            off: 0, op: 0, as: 0, chk: 6'b0};
      case (k)
        K_ADD, K_SUB: begin
          e.ra = 5'(prn[i]); e.rb = 5'(prm[i]); e.rw = 5'(prd[i]);
          e.op = 2'd0; e.as = (k == K_SUB); e.wer = 1; e.chk = 6'b111011;
        end
        K_ADDI, K_SUBI: begin
          e.ra = 5'(prn[i]); e.rb = 5'(prn[i]); e.rw = 5'(prd[i]);
          e.off = longint'(pimm[i]); e.op = 2'd2; e.as = (k == K_SUBI);
          e.wer = 1; e.chk = 6'b111111;
        end
        K_LDUR, K_STUR: begin
          e.ra = 5'(prd[i]); e.rb = 5'(prn[i]); e.rw = 5'(prd[i]);
          e.off = longint'(pimm[i]); e.op = 2'd1; e.as = 1'b0; e.chk = 6'b111111;
          if (k == K_LDUR) begin e.lat = 4; e.wer = 1; end
          else e.wem = 1;
        end
        K_CBZ, K_CBNZ: begin
          e.ra = 5'(prd[i]); e.rb = 5'd31; e.op = 2'd0; e.as = 1'b0; e.chk = 6'b110011;
        end
        default: ;
      endcase
      taken = (k == K_CBZ && flag_z) || (k == K_CBNZ && !flag_z);
      if (k == K_B || taken) mpc = mpc + longint'(pimm[i]) * 4;
      else mpc = mpc + 64'd4;
      e.pc = mpc;
      e.ret = 32'(s + 1);
      exp_q.push_back(e);
    end
    exp_pc  = mpc;
    exp_ret = 32'(exp_q.size());
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) begin
      pk[i] = K_BAD; prd[i] = 0; prn[i] = 0; prm[i] = 0; pimm[i] = 0;
    end
  endtask

  task automatic put(input int a, input kind_t k, input int rd, input int rn, input int rm, input int imm);
    pk[a] = k; prd[a] = rd; prn[a] = rn; prm[a] = rm; pimm[a] = imm;
  endtask

  task automatic rand_prog();
    int    r;
    kind_t k;
    for (int i = 0; i < 64; i++) begin
      r = int'($urandom_range(0, 99));
      k = (r < 14) ? K_ADD  : (r < 28) ? K_SUB  : (r < 40) ? K_ADDI : (r < 52) ? K_SUBI :
          (r < 64) ? K_LDUR : (r < 76) ? K_STUR : (r < 84) ? K_B    : (r < 94) ? K_CBZ  :
          (r < 97) ? K_CBNZ : K_BAD;
      case (k)
        K_ADDI, K_SUBI:     r = int'($urandom_range(0, 4095));
        K_LDUR, K_STUR:     r = int'($urandom_range(0, 511)) - 256;
        K_B, K_CBZ, K_CBNZ: r = int'($urandom_range(0, 10)) - 4;
        default:            r = int'($urandom_range(0, 1));
      endcase
      put(i, k, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
          int'($urandom_range(0, 31)), r);
    end
  endtask

  task automatic load_rom();
    for (int i = 0; i < 64; i++) rom[i] = enc(pk[i], prd[i], prn[i], prm[i], pimm[i]);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; start = 1'b0;
    #1;
    chk("rst_pc", pc, 64'd0);
    chk("rst_imem_addr", imem_addr, 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_retired", 64'(retired), 64'd0);
    chk("rst_we", 64'({WE_reg, WE_mem}), 64'd0);
    chk("rst_fields", 64'({Ra, Rb, Rw, OP_MEM_I, ADD_SUB}), 64'd0);
    chk("rst_offset", OFFSET, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic pulse_start(input int len);
    @(posedge clk); #1 start = 1'b1;
    repeat (len) @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_prog(input bit fz, input int steps);
    int t;
    load_rom();
    flag_z = fz;
    flags  = {5'($urandom), fz};
    do_reset();
    exp_q.delete();
    build_model(steps);
    mon_en = 1;
    pulse_start(1);
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      flags = {5'($urandom), flag_z};
      t++;
    end
    if (exp_q.size() != 0) begin
      n_checks++; n_err++;
      $display("FAIL drain_timeout: %0d retirements outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    if (exp_halt) begin
      repeat (6) @(negedge clk);
      chk("halt_flag", 64'(halted), 64'd1);
      chk("halt_pc", pc, exp_pc);
      chk("halt_retired", 64'(retired), 64'(exp_ret));
      chk("halt_no_we", 64'(wer_cnt + wem_cnt), 64'd0);
      pulse_start(3);
      repeat (3) @(negedge clk);
      chk("halt_start_pc", pc, exp_pc);
      chk("halt_start_flag", 64'(halted), 64'd1);
      chk("halt_start_retired", 64'(retired), 64'(exp_ret));
    end else begin
      chk("no_halt", 64'(halted), 64'd0);
    end
    mon_en = 0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; flags = 6'd0;
    for (int i = 0; i < 64; i++) rom[i] = 32'hFFFF_FFFF;

    // ADDI/SUB/STUR/LDUR/taken CBZ then an all-ones word that must halt.
    clear_prog();
    put(0, K_ADDI, 1, 31, 0, 5);
    put(1, K_SUB,  3, 1, 2, 0);
    put(2, K_STUR, 1, 2, 0, -8);
    put(3, K_LDUR, 4, 2, 0, -8);
    put(4, K_CBZ,  5, 0, 0, 3);
    run_prog(1'b1, 30);

    // Untaken CBZ and a backward B forming a loop.
    clear_prog();
    put(0, K_ADD, 2, 3, 4, 0);
    put(1, K_CBZ, 7, 0, 0, 3);
    put(2, K_B,   0, 0, 0, -1);
    run_prog(1'b0, 9);

    // Reset asserted while an ADD is in EXEC.
    clear_prog();
    put(0, K_ADD, 9, 10, 11, 0);
    load_rom();
    do_reset();
    pulse_start(1);
    repeat (2) @(posedge clk);
    #1;
    chk("exec_we_reg", 64'(WE_reg), 64'd1);
    chk("exec_rw", 64'(Rw), 64'd9);
    rst_n = 1'b0;
    #1;
    chk("arst_we_reg", 64'(WE_reg), 64'd0);
    chk("arst_pc", pc, 64'd0);
    chk("arst_retired", 64'(retired), 64'd0);
    chk("arst_rw", 64'(Rw), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    for (int p = 0; p < 14; p++) begin
      rand_prog();
      run_prog(1'($urandom_range(0, 1)), 25);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/uc_processador.md
# uc_processador

Multicycle control unit that sits directly upstream of the processor datapath (register bank, ULA, data memory). It fetches 32-bit LEGv8-subset instructions from a synchronous instruction ROM, decodes them, and drives every datapath control input (register addresses, write enables, OFFSET, OP_MEM_I, ADD_SUB). It consumes the datapath flags to resolve conditional branches, and it owns the PC, the instruction register, and a retired-instruction counter.

## Interface
Parameters:
- RESET_PC, 64'd0, PC value loaded at reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  leaves IDLE when high; ignored in every other state.
- imem_addr  out  64  instruction byte address (= PC).
- imem_data  in  32  instruction word; valid one cycle after imem_addr is presented.
- Ra, Rb, Rw  out  5  datapath register addresses.
- WE_reg, WE_mem  out  1  datapath write enables.
- OFFSET  out  64  sign-extended immediate to the datapath.
- OP_MEM_I  out  2  operation select: 0 = ADD/SUB, 1 = LDUR/STUR, 2 = ADDI/SUBI.
- ADD_SUB  out  1  0 = add, 1 = subtract.
- flags  in  6  datapath flags; bit 0 = zero. Bits 5:1 are ignored.
- pc  out  64  current PC.
- halted  out  1  sticky; set on an unrecognised opcode.
- retired  out  32  count of completed instructions; wraps at 2^32.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE → FETCH when start = 1.
- FETCH: drive imem_addr = PC. Go to DECODE.
- DECODE: latch IR ← imem_data. Register the field outputs. Go to EXEC, or to HALT if the opcode is unrecognised.
- EXEC: go to WB for LDUR; otherwise go to FETCH.
- WB: go to FETCH.
- HALT: terminal. Only rst_n leaves it. start is ignored.
- Decode (Rd = IR[4:0], Rn = IR[9:5], Rm = IR[20:16]):
  - ADD 10001011000 / SUB 11001011000 (IR[31:21]): Ra = Rn, Rb = Rm, Rw = Rd, OP = 0, ADD_SUB = 0 / 1, WE_reg = 1 in EXEC.
  - ADDI 1001000100 / SUBI 1101000100 (IR[31:22]): Ra = Rb = Rn, Rw = Rd, OFFSET = zero-extended IR[21:10], OP = 2, ADD_SUB = 0 / 1, WE_reg = 1 in EXEC.
  - LDUR 11111000010: Ra = Rd, Rb = Rn, Rw = Rd, OFFSET = sign-extended IR[20:12], OP = 1, ADD_SUB = 0. WE_reg = 1 in WB only.
  - STUR 11111000000: same fields as LDUR. WE_mem = 1 in EXEC only. The datapath address is dinB + OFFSET and the store data is doutA.
  - B 000101 (IR[31:26]): no datapath writes. PC ← PC + (sext(IR[25:0]) << 2).
  - CBZ 10110100 (IR[31:24]): Ra = Rd, Rb = 31 (XZR), OP = 0, ADD_SUB = 0. In EXEC, if flags[0] = 1 then PC ← PC + (sext(IR[23:5]) << 2), else PC ← PC + 4.
- All other instructions: PC ← PC + 4 at the end of EXEC, or at the end of WB for LDUR.
- retired increments on the same edge that updates the PC.
- PC arithmetic is 64-bit modulo 2^64. Wrap-around is silent.
- The register-31-reads-zero contract belongs to the datapath. This block relies on it.

## Timing
- Reset values: all outputs 0, except pc = imem_addr = RESET_PC. State = IDLE.
- Latency: 3 cycles per instruction (FETCH, DECODE, EXEC); LDUR takes 4 (adds WB). From a start pulse, the first FETCH is in the next cycle.
- WE_reg and WE_mem are high for exactly one cycle per qualifying instruction, and never outside EXEC/WB.
- Ra, Rb, Rw, OFFSET, OP_MEM_I and ADD_SUB are registered. They are stable from DECODE+1 through the end of EXEC/WB, and hold their last values otherwise.
- flags is sampled combinationally at the end of EXEC.
- On halt, PC keeps the address of the offending instruction and retired is not incremented.
- rst_n assertion mid-instruction clears all state immediately. Write enables drop asynchronously, with no partial write committed after reset asserts.
- start held high continuously still performs only one IDLE exit.

## Configuration
- UC_CBNZ_EN:
  - Defined: CBNZ (opcode 10110101) decodes exactly like CBZ, but branches when flags[0] = 0.
  - Undefined: opcode 10110101 is unrecognised and halts.

## Test plan
- Reset then start; ROM[0] = ADDI X1, XZR, #5 → Ra = Rb = 31, OFFSET = 5, OP_MEM_I = 2, WE_reg for one cycle in cycle 3, pc = 4, retired = 1.
- SUB X3, X1, X2 → Ra = 1, Rb = 2, Rw = 3, ADD_SUB = 1, OP_MEM_I = 0, 3-cycle latency.
- STUR X1, [X2, #-8] then LDUR X4, [X2, #-8] → OFFSET = 64'hFFFF_FFFF_FFFF_FFF8; WE_mem in EXEC; WE_reg only in WB; LDUR takes 4 cycles.
- CBZ X5, #3 with flags[0] = 1 → pc advances by 12; with flags[0] = 0 → pc advances by 4. B #-1 at pc = 8 → pc = 4.
- Opcode 0xFFFFFFFF → halted = 1, no write enables, pc frozen; start ignored; rst_n clears halted.
- Assert rst_n low during EXEC of ADD → WE_reg falls within the same cycle, pc = RESET_PC, retired = 0.
